// File: rtl/coh_bus_arbiter.sv
// Snooping-bus arbiter and MESI coherence controller for NUM_CACHES L1 caches.
// Optional memory watchdog: define COH_ARB_TIMEOUT_EN.
module coh_bus_arbiter #(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int TIMEOUT    = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CACHES-1:0]          c_hreq,
    input  logic [3*NUM_CACHES-1:0]        c_ttype,
    input  logic [ADDR_W*NUM_CACHES-1:0]   c_haddr,
    input  logic [LINE_W*NUM_CACHES-1:0]   c_hwdata,
    output logic [NUM_CACHES-1:0]          c_hgrant,
    output logic [NUM_CACHES-1:0]          c_hready,
    output logic [NUM_CACHES-1:0]          c_hrsp,
    output logic [LINE_W-1:0]              c_hrdata,
    input  logic [2*NUM_CACHES-1:0]        s_state,
    input  logic [LINE_W*NUM_CACHES-1:0]   s_data,
    output logic [ADDR_W-1:0]              saddr,
    output logic [NUM_CACHES-1:0]          snoop_valid,
    output logic [2*NUM_CACHES-1:0]        sn_state,
    output logic                           other_copies,
    output logic                           m_hreq,
    output logic                           m_hwrite,
    output logic [ADDR_W-1:0]              m_haddr,
    output logic [LINE_W-1:0]              m_hwdata,
    input  logic                           m_hready,
    input  logic [LINE_W-1:0]              m_hrdata
);

    localparam int PW = (NUM_CACHES > 2) ? $clog2(NUM_CACHES) : 1;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SNOOP   = 4'd1;
    localparam logic [3:0] S_FLUSH_A = 4'd2;
    localparam logic [3:0] S_FLUSH_D = 4'd3;
    localparam logic [3:0] S_WB_A    = 4'd4;
    localparam logic [3:0] S_WB_D    = 4'd5;
    localparam logic [3:0] S_MEM_A   = 4'd6;
    localparam logic [3:0] S_MEM_D   = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam logic [PW-1:0] PTR_RST = PW'(NUM_CACHES - 1);
    localparam logic [NUM_CACHES-1:0] ONE = {{(NUM_CACHES-1){1'b0}}, 1'b1};

    logic [2:0]        ttype_a [NUM_CACHES];
    logic [ADDR_W-1:0] haddr_a [NUM_CACHES];
    logic [LINE_W-1:0] hwdat_a [NUM_CACHES];
    logic [1:0]        st_a    [NUM_CACHES];
    logic [LINE_W-1:0] sdat_a  [NUM_CACHES];

    for (genvar g = 0; g < NUM_CACHES; g++) begin : g_unpack
        assign ttype_a[g] = c_ttype[3*g +: 3];
        assign haddr_a[g] = c_haddr[ADDR_W*g +: ADDR_W];
        assign hwdat_a[g] = c_hwdata[LINE_W*g +: LINE_W];
        assign st_a[g]    = s_state[2*g +: 2];
        assign sdat_a[g]  = s_data[LINE_W*g +: LINE_W];
    end

    logic [3:0]            state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [NUM_CACHES-1:0] grant_q, grant_d;
    logic [NUM_CACHES-1:0] hready_q, hready_d;
    logic [NUM_CACHES-1:0] hrsp_q, hrsp_d;
    logic [LINE_W-1:0]     rdata_q, rdata_d;
    logic [ADDR_W-1:0]     saddr_q, saddr_d;
    logic [2:0]            ttype_q, ttype_d;
    logic [NUM_CACHES-1:0] sv_q, sv_d;
    logic [2*NUM_CACHES-1:0] sns_q, sns_d;

    logic                  rr_found;
    logic [PW-1:0]         rr_win;
    logic [PW-1:0]         rr_idx;
    logic                  hit;
    logic                  any_m;
    logic [LINE_W-1:0]     or_data;
    logic [NUM_CACHES-1:0] win_oh;

    assign win_oh = ONE << ptr_q;

    // Round-robin search starts just after the last winner.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = ptr_q;
        rr_idx   = '0;
        for (int i = 1; i <= NUM_CACHES; i++) begin
            rr_idx = PW'((int'(ptr_q) + i) % NUM_CACHES);
            if (!rr_found && c_hreq[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

    always_comb begin
        hit     = 1'b0;
        any_m   = 1'b0;
        or_data = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (PW'(i) != ptr_q && st_a[i] != 2'b00) begin
                hit     = 1'b1;
                or_data = or_data | sdat_a[i];
                if (st_a[i] == 2'b11) any_m = 1'b1;
            end
        end
    end

`ifdef COH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;
    assign waiting = (state_q == S_FLUSH_A) || (state_q == S_WB_A) ||
                     (state_q == S_MEM_A) || (state_q == S_MEM_D);
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        hready_d = '0;
        hrsp_d   = '0;
        rdata_d  = rdata_q;
        saddr_d  = saddr_q;
        ttype_d  = ttype_q;
        sv_d     = '0;
        sns_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    ptr_d    = rr_win;
                    grant_d  = ONE << rr_win;
                    hready_d = ONE << rr_win;
                    saddr_d  = haddr_a[rr_win];
                    ttype_d  = ttype_a[rr_win];
                    state_d  = S_SNOOP;
                end
            end
            S_SNOOP: begin
                if (ttype_q == 3'b000) begin
                    hrsp_d  = win_oh;
                    state_d = S_DONE;
                end else if (ttype_q[2]) begin
                    state_d = S_FLUSH_A;
                end else begin
                    for (int i = 0; i < NUM_CACHES; i++) begin
                        if (PW'(i) != ptr_q) begin
                            if (ttype_q[0]) begin
                                sv_d[i] = 1'b1;
                            end else if (ttype_q[1] && st_a[i] != 2'b00) begin
                                sv_d[i]          = 1'b1;
                                sns_d[2*i +: 2] = 2'b01;
                            end
                        end
                    end
                    if (ttype_q[1] && hit) begin
                        rdata_d  = or_data;
                        hready_d = win_oh;
                        state_d  = any_m ? S_WB_A : S_DONE;
                    end else if (ttype_q[1]) begin
                        state_d = S_MEM_A;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FLUSH_A: begin
                if (m_hready) begin
                    hready_d = win_oh;
                    state_d  = S_FLUSH_D;
                end
            end
            S_FLUSH_D: begin
                ttype_d = {1'b0, ttype_q[1:0]};
                state_d = (|ttype_q[1:0]) ? S_SNOOP : S_DONE;
            end
            S_WB_A: if (m_hready) state_d = S_WB_D;
            S_WB_D: state_d = S_DONE;
            S_MEM_A: if (m_hready) state_d = S_MEM_D;
            S_MEM_D: begin
                if (m_hready) begin
                    rdata_d  = m_hrdata;
                    hready_d = win_oh;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = '0;
                saddr_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef COH_ARB_TIMEOUT_EN
        cnt_d = '0;
        if (waiting && !m_hready) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                hrsp_d   = win_oh;
                hready_d = '0;
                state_d  = S_DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= PTR_RST;
            grant_q  <= '0;
            hready_q <= '0;
            hrsp_q   <= '0;
            rdata_q  <= '0;
            saddr_q  <= '0;
            ttype_q  <= '0;
            sv_q     <= '0;
            sns_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            hready_q <= hready_d;
            hrsp_q   <= hrsp_d;
            rdata_q  <= rdata_d;
            saddr_q  <= saddr_d;
            ttype_q  <= ttype_d;
            sv_q     <= sv_d;
            sns_q    <= sns_d;
        end
    end

`ifdef COH_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign c_hgrant     = grant_q;
    assign c_hready     = hready_q;
    assign c_hrsp       = hrsp_q;
    assign c_hrdata     = rdata_q;
    assign saddr        = saddr_q;
    assign snoop_valid  = sv_q;
    assign sn_state     = sns_q;
    assign other_copies = hit && (state_q != S_IDLE);

    assign m_hreq   = (state_q >= S_FLUSH_A) && (state_q <= S_MEM_D);
    assign m_hwrite = (state_q >= S_FLUSH_A) && (state_q <= S_WB_D);
    assign m_haddr  = m_hreq ? saddr_q : '0;

    always_comb begin
        m_hwdata = '0;
        if (state_q == S_FLUSH_D)   m_hwdata = hwdat_a[ptr_q];
        else if (state_q == S_WB_D) m_hwdata = rdata_q;
    end

endmodule

// File: tb/tb_coh_bus_arbiter.sv
// Randomised bench for coh_bus_arbiter against a transaction-level model.
// Timeout scenario runs only when COH_ARB_TIMEOUT_EN is defined.
module tb_coh_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    c_hreq;
    logic [3*N-1:0]  c_ttype;
    logic [AW*N-1:0] c_haddr;
    logic [LW*N-1:0] c_hwdata;
    logic [N-1:0]    c_hgrant, c_hready, c_hrsp;
    logic [LW-1:0]   c_hrdata;
    logic [2*N-1:0]  s_state;
    logic [LW*N-1:0] s_data;
    logic [AW-1:0]   saddr;
    logic [N-1:0]    snoop_valid;
    logic [2*N-1:0]  sn_state;
    logic            other_copies;
    logic            m_hreq, m_hwrite;
    logic [AW-1:0]   m_haddr;
    logic [LW-1:0]   m_hwdata;
    logic            m_hready;
    logic [LW-1:0]   m_hrdata;

    always #5 clk = ~clk;

    coh_bus_arbiter #(
        .NUM_CACHES(N), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .c_hreq(c_hreq), .c_ttype(c_ttype), .c_haddr(c_haddr),
        .c_hwdata(c_hwdata), .c_hgrant(c_hgrant), .c_hready(c_hready),
        .c_hrsp(c_hrsp), .c_hrdata(c_hrdata), .s_state(s_state),
        .s_data(s_data), .saddr(saddr), .snoop_valid(snoop_valid),
        .sn_state(sn_state), .other_copies(other_copies),
        .m_hreq(m_hreq), .m_hwrite(m_hwrite), .m_haddr(m_haddr),
        .m_hwdata(m_hwdata), .m_hready(m_hready), .m_hrdata(m_hrdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [LW-1:0] got,
                         input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Memory model: ready after mem_delay wait cycles per phase.
    int            mem_delay = 0;
    bit            mem_stuck = 0;
    int            wcnt = 0;
    bit            wphase = 0;
    bit            rphase = 0;
    int            mreq_cycles = 0;
    logic [AW-1:0] wr_addr [$];
    logic [LW-1:0] wr_data [$];
    logic [AW-1:0] rd_addr [$];

    assign m_hrdata = pat(m_haddr);

    initial m_hready = 1'b0;

    always @(negedge clk) begin
        if (!m_hreq) begin
            wcnt = 0; m_hready = 1'b0; wphase = 0; rphase = 0;
        end else begin
            m_hready = !mem_stuck && (wcnt >= mem_delay);
            if (m_hready) wcnt = 0;
            else wcnt++;
        end
        #1;
        if (m_hreq) mreq_cycles++;
        if (m_hreq && m_hwrite) begin
            if (wphase) begin
                wr_data.push_back(m_hwdata);
                wphase = 0;
            end else if (m_hready) begin
                wr_addr.push_back(m_haddr);
                wphase = 1;
            end
        end else if (m_hreq && m_hready) begin
            if (!rphase) rd_addr.push_back(m_haddr);
            rphase = !rphase;
        end
    end

    logic [1:0]    st [N];
    logic [LW-1:0] sd [N];

    task automatic do_txn(input int w, input logic [2:0] tt,
                          input logic [AW-1:0] addr,
                          input logic [LW-1:0] wd, input bit exp_to);
        logic [LW-1:0] or_d, exp_data, last_data;
        logic [AW-1:0] ew_a [$];
        logic [LW-1:0] ew_d [$];
        logic [AW-1:0] er_a [$];
        logic [N-1:0]  exp_sv, sv_seen, hrsp_seen;
        logic [2*N-1:0] exp_sns, sns_seen, mask;
        bit hit, anym, legal, done;
        int cycles;
        hit = 0; anym = 0; or_d = '0; exp_data = '0;
        exp_sv = '0; exp_sns = '0; mask = '0;
        legal = (tt != 3'b000);
        for (int j = 0; j < N; j++)
            if (j != w && st[j] != 2'b00) begin
                hit = 1; or_d |= sd[j];
                if (st[j] == 2'b11) anym = 1;
            end
        if (legal && tt[2]) begin ew_a.push_back(addr); ew_d.push_back(wd); end
        if (legal && (tt[1] || tt[0]))
            for (int j = 0; j < N; j++)
                if (j != w && (tt[0] || st[j] != 2'b00)) begin
                    exp_sv[j] = 1'b1;
                    mask[2*j +: 2] = 2'b11;
                    exp_sns[2*j +: 2] = tt[0] ? 2'b00 : 2'b01;
                end
        if (legal && tt[1]) begin
            if (hit) begin
                exp_data = or_d;
                if (anym) begin ew_a.push_back(addr); ew_d.push_back(or_d); end
            end else begin
                exp_data = pat(addr);
                if (!exp_to) er_a.push_back(addr);
            end
        end

        @(negedge clk);
        wr_addr.delete(); wr_data.delete(); rd_addr.delete();
        mreq_cycles = 0;
        for (int j = 0; j < N; j++) begin
            s_state[2*j +: 2] = st[j];
            s_data[LW*j +: LW] = (st[j] != 2'b00) ? sd[j] : '0;
        end
        c_ttype[3*w +: 3] = tt;
        c_haddr[AW*w +: AW] = addr;
        c_hwdata[LW*w +: LW] = wd;
        c_hreq[w] = 1'b1;
        @(negedge clk); #2;
        check("grant", c_hgrant, (1 << w));
        check("grant_ready", c_hready, (1 << w));
        check("saddr", saddr, addr);
        check("other_copies", other_copies, hit);
        c_hreq[w] = 1'b0;
        cycles = 1; done = 0;
        sv_seen = '0; sns_seen = '0; hrsp_seen = '0; last_data = '0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk); #2;
            if (c_hgrant == '0) done = 1;
            else begin
                cycles++;
                if (c_hready[w]) last_data = c_hrdata;
                if (|snoop_valid) begin
                    sv_seen |= snoop_valid; sns_seen = sn_state;
                end
                hrsp_seen |= c_hrsp;
            end
        end
        check("txn_complete", done, 1'b1);
        check("hrsp", hrsp_seen, (!legal || exp_to) ? (1 << w) : 0);
        check("snoop_valid", sv_seen, exp_sv);
        check("sn_state", sns_seen & mask, exp_sns);
        if (legal && tt[1] && !exp_to) check("rdata", last_data, exp_data);
        if (legal && tt == 3'b010 && hit && !anym)
            check("clean_hit_cycles", cycles, 2);
        if (exp_to) check("timeout_cycles", mreq_cycles, TO);
        check("wr_cnt", wr_addr.size(), ew_a.size());
        check("wr_data_cnt", wr_data.size(), ew_d.size());
        for (int i = 0; i < ew_a.size() && i < wr_addr.size(); i++)
            check("wr_addr", wr_addr[i], ew_a[i]);
        for (int i = 0; i < ew_d.size() && i < wr_data.size(); i++)
            check("wr_data", wr_data[i], ew_d[i]);
        check("rd_cnt", rd_addr.size(), er_a.size());
        for (int i = 0; i < er_a.size() && i < rd_addr.size(); i++)
            check("rd_addr", rd_addr[i], er_a[i]);
        check("mreq_idle", m_hreq, 1'b0);
    endtask

    task automatic clear_st();
        for (int j = 0; j < N; j++) begin st[j] = 2'b00; sd[j] = '0; end
    endtask

    task automatic round_robin();
        int last, got, ngrant;
        logic [N-1:0] prev;
        clear_st();
        @(negedge clk);
        s_state = '0; s_data = '0;
        c_ttype = {N{3'b001}};
        c_hreq = '1;
        last = N - 1; ngrant = 0; prev = '0;
        for (int k = 0; k < 60 && ngrant < 5; k++) begin
            @(negedge clk); #2;
            if (c_hgrant != '0 && prev == '0) begin
                got = -1;
                for (int j = 0; j < N; j++) if (c_hgrant[j]) got = j;
                last = (last + 1) % N;
                check("rr_order", got, last);
                ngrant++;
            end
            prev = c_hgrant;
        end
        check("rr_count", ngrant, 5);
        c_hreq = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int w, mode, o;
        logic [2:0] tt;
        logic [LW-1:0] line;
        rst_n = 1'b0;
        c_hreq = '0; c_ttype = '0; c_haddr = '0; c_hwdata = '0;
        s_state = '0; s_data = '0;
        clear_st();
        repeat (3) @(negedge clk);
        #2;
        check("rst_grant", c_hgrant, 0);
        check("rst_ready", c_hready, 0);
        check("rst_rsp", c_hrsp, 0);
        check("rst_mreq", m_hreq, 0);
        check("rst_sv", snoop_valid, 0);
        check("rst_sns", sn_state, 0);
        check("rst_saddr", saddr, 0);
        check("rst_rdata", c_hrdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        round_robin();

        clear_st(); st[0] = 2'b10; sd[0] = {32{8'hA5}};
        do_txn(2, 3'b010, 32'h0000_1000, '0, 0);

        clear_st(); st[3] = 2'b11; sd[3] = rnd_line();
        do_txn(1, 3'b010, 32'h0000_2040, '0, 0);

        clear_st(); mem_delay = 5;
        do_txn(0, 3'b010, 32'h0000_3080, '0, 0);
        mem_delay = 0;

        clear_st(); line = rnd_line();
        st[1] = 2'b01; sd[1] = line; st[2] = 2'b01; sd[2] = line;
        do_txn(3, 3'b111, 32'h0000_40C0, rnd_line(), 0);

        clear_st();
        do_txn(2, 3'b000, 32'h0000_5000, rnd_line(), 0);

`ifdef COH_ARB_TIMEOUT_EN
        clear_st(); mem_stuck = 1;
        do_txn(1, 3'b010, 32'h0000_6000, '0, 1);
        mem_stuck = 0;
`endif

        for (int k = 0; k < 25; k++) begin
            clear_st();
            w = $urandom_range(0, N - 1);
            tt = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 3);
            o = (w + 1 + $urandom_range(0, N - 2)) % N;
            line = rnd_line();
            if (mode == 1) begin st[o] = 2'b10; sd[o] = line; end
            if (mode == 2) begin st[o] = 2'b11; sd[o] = line; end
            if (mode == 3)
                for (int j = 0; j < N; j++)
                    if ($urandom_range(0, 1) == 1) begin
                        st[j] = 2'b01; sd[j] = line;
                    end
            if (mode == 3 && $urandom_range(0, 1) == 1) st[w] = 2'b01;
            mem_delay = $urandom_range(0, 3);
            do_txn(w, tt, $urandom & 32'hFFFF_FFE0, rnd_line(), 0);
        end
        mem_delay = 0;

        clear_st(); mem_stuck = 1;
        @(negedge clk);
        s_state = '0; s_data = '0;
        c_ttype[3 +: 3] = 3'b010;
        c_haddr[AW +: AW] = 32'h0000_7000;
        c_hreq[1] = 1'b1;
        @(negedge clk);
        c_hreq[1] = 1'b0;
        @(negedge clk); #2;
        check("mid_mreq", m_hreq, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("mid_rst_mreq", m_hreq, 1'b0);
        check("mid_rst_grant", c_hgrant, 0);
        @(negedge clk);
        rst_n = 1'b1; mem_stuck = 0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coh_bus_arbiter.md
# coh_bus_arbiter

Parametrised snooping-bus arbiter and coherence controller for the MESI cache-coherence lab. It sits between NUM_CACHES private L1 cache controllers and a single shared memory port: it grants the bus round-robin, broadcasts the snoop address, drives next-state commands to snoopers, sources lines cache-to-cache when possible, and sequences flushes, write-backs and memory fills. It generalises the fixed four-cache arbiter to N caches, adds an error response, and optionally adds a memory-timeout watchdog.

## Interface
- NUM_CACHES, 4, caches on the bus (2..8).
- ADDR_W, 32, address width.
- LINE_W, 256, cache-line width in bits.
- TIMEOUT, 64, memory wait limit in cycles (used only with the timeout feature).
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- c_hreq  in  N  per-cache bus request.
- c_ttype  in  3N  per-cache transaction {flush, read, inv}; 3'b000 is illegal.
- c_haddr  in  ADDR_W*N  per-cache line address.
- c_hwdata  in  LINE_W*N  per-cache flush data.
- c_hgrant / c_hready / c_hrsp  out  N each  grant, data/phase ready, error response.
- c_hrdata  out  LINE_W  read data, valid to the granted cache when its c_hready is high.
- s_state  in  2N  snooper MESI state for saddr (00 I, 01 S, 10 E, 11 M).
- s_data  in  LINE_W*N  snooper line data for saddr (zero when not hit).
- saddr  out  ADDR_W  broadcast snoop address.
- snoop_valid  out  N  apply sn_state this cycle.
- sn_state  out  2N  commanded next state per snooper.
- other_copies  out  1  another cache holds saddr (non-I).
- m_hreq / m_hwrite  out  1 each  memory request, 1 = write.
- m_haddr  out  ADDR_W; m_hwdata  out  LINE_W.
- m_hready  in  1; m_hrdata  in  LINE_W.

## Operation
- Reset: all outputs 0, sn_state all I, state IDLE, last-grant pointer = NUM_CACHES-1.
- IDLE: search from pointer+1 with wrap; first asserted c_hreq wins; assert c_hgrant and c_hready for winner only; pointer <= winner; go SNOOP. No requests: stay.
- saddr = winner's c_haddr while granted (registered at grant). other_copies = OR of non-I s_state excluding winner; combinational.
- SNOOP (one cycle) decodes c_ttype:
  - flush=1: go FLUSH_A; c_hready low until memory write accepted.
  - read=1, some other hit: c_hrdata = OR of other s_data; pulse c_hready; any hit in M -> WB_A, else DONE.
  - read=1, no hit: MEM_A.
  - inv only: DONE.
- Snoop commands, issued in SNOOP, one cycle of snoop_valid: inv=1 -> all others I; read-only -> others with non-I go S; winner never gets snoop_valid.
- FLUSH_A: wait m_hready; m_hwrite=1, m_haddr=winner address; FLUSH_D: m_hwdata=c_hwdata, pulse c_hready; then continue as read/inv decode (re-enter SNOOP) if read or inv set, else DONE.
- WB_A/WB_D: write captured dirty line to memory at captured address.
- MEM_A: wait m_hready, issue read; MEM_D: wait m_hready, return m_hrdata with c_hready pulse; drop m_hreq.
- DONE: clear c_hgrant/c_hready; return IDLE.
- Illegal c_ttype: c_hrsp pulse one cycle in SNOOP, DONE, no memory traffic.
- c_hreq deasserted mid-transaction: ignored; transaction completes.

## Timing
- Grant: 1 cycle after c_hreq sampled in IDLE; SNOOP next cycle.
- Cache-to-cache read: data on c_hrdata 2 cycles after grant; clean hit frees bus at cycle 3.
- m_hreq held high from first memory phase until final memory handshake.
- Minimum gap between back-to-back grants: 1 IDLE cycle.
- rst_n low mid-transaction: immediate return to reset values; memory transaction abandoned.

## Configuration
- COH_ARB_TIMEOUT_EN defined: counter runs in FLUSH_A, WB_A, MEM_A, MEM_D; reaching TIMEOUT cycles without m_hready pulses winner c_hrsp, drops m_hreq, goes DONE.
- Undefined: no counter; arbiter waits indefinitely for m_hready.

## Test plan
- Round-robin: NUM_CACHES=4, all request continuously after reset -> grants 0,1,2,3,0 in order.
- Clean shared read: cache 2 reads, cache 0 in E with data 0xA5.. -> cache 2 gets 0xA5.., cache 0 commanded S, no memory access.
- Dirty hit: cache 1 reads, cache 3 in M -> data to cache 1, memory write of same line and address, cache 3 commanded S.
- Miss with slow memory: m_hready low 5 cycles -> m_hreq held, data returned after handshake, other_copies=0.
- Flush then read-exclusive: ttype 3'b111 -> memory write of c_hwdata, then all others commanded I.
- Timeout (macro on, TIMEOUT=8): m_hready stuck low -> c_hrsp pulse at cycle 8, m_hreq low, IDLE; illegal ttype 000 -> c_hrsp, no memory traffic.
